matrix_mult_seq: RTL and testbench

MATRIX_MULT_SEQ -- requirements
Module: matrix_mult_seq

---
 rtl/matmul_pkg.sv | 23 ++
 rtl/matmul_mac.sv | 60 ++++++
 rtl/matrix_mult_seq.sv | 151 +++++++++++++++
 tb/tb_matrix_mult_seq.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared definitions for the sequential matrix multiplier: FSM state encoding,
// default geometry, index width and the flat-vector element offset helper.
package matmul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_DW      = 8;
  localparam int DEF_MAX_DIM = 4;
  localparam int DEF_OW      = 16;

  // Loop indices share the width of the m/k/n ports so they compare directly.
  localparam int IDX_W = 8;

  // Position of element (r,c) inside a row-major flattened square matrix.
  function automatic int elem_off(input int r, input int c, input int max_dim);
    return r * max_dim + c;
  endfunction

endpackage

// File: rtl/matmul_mac.sv
// Signed multiply-accumulate slice: one DW x DW product per step, an
// accumulator wide enough for MAX_DIM products, and the OW-bit output
// conversion. Define MATMUL_SATURATE_EN to clamp results to the signed OW
// range; otherwise the low OW bits are kept (two's-complement wrap).
module matmul_mac #(
  parameter int DW      = 8,
  parameter int MAX_DIM = 4,
  parameter int OW      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 step,
  input  logic                 clear,
  input  logic                 last,
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  output logic signed [OW-1:0] result
);

  localparam int AW = 2 * DW + $clog2(MAX_DIM);
  localparam int SW = (AW > OW) ? AW : OW;

  logic signed [2*DW-1:0] prod;
  logic signed [AW-1:0]   acc;
  logic signed [AW-1:0]   sum;
  logic signed [SW-1:0]   sum_ext;

  assign prod    = a * b;
  assign sum     = acc + AW'(prod);
  assign sum_ext = SW'(sum);

  // Accumulator: cleared on a new job and after each finished dot product.
  always_ff @(posedge clk) begin
    if (!reset) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (step) begin
      acc <= last ? '0 : sum;
    end
  end

`ifdef MATMUL_SATURATE_EN
  localparam logic signed [SW-1:0] SAT_MAX = {{(SW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {{(SW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  // Clamp the running sum into the signed OW range.
  always_comb begin
    result = OW'(sum_ext);
    if (sum_ext > SAT_MAX) begin
      result = OW'(SAT_MAX);
    end else if (sum_ext < SAT_MIN) begin
      result = OW'(SAT_MIN);
    end
  end
`else
  assign result = OW'(sum_ext);
`endif

endmodule

// File: rtl/matrix_mult_seq.sv
// Sequential signed matrix multiplier C = A x B for operands up to
// MAX_DIM x MAX_DIM, one product per enabled cycle (p fastest, then j, then i).
// Optional build macro: MATMUL_SATURATE_EN (clamp C elements instead of wrap).
// Handshake: start is sampled only in IDLE with enable high; busy is high
// while multiplying; done is a one-cycle pulse (stretched while enable is low)
// and err qualifies it. C and err stay valid until the next accepted start.
module matrix_mult_seq
  import matmul_pkg::*;
#(
  parameter int DW      = DEF_DW,
  parameter int MAX_DIM = DEF_MAX_DIM,
  parameter int OW      = DEF_OW
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          start,
  input  logic [7:0]                    m,
  input  logic [7:0]                    k,
  input  logic [7:0]                    n,
  input  logic [MAX_DIM*MAX_DIM*DW-1:0] A,
  input  logic [MAX_DIM*MAX_DIM*DW-1:0] B,
  output logic [MAX_DIM*MAX_DIM*OW-1:0] C,
  output logic                          busy,
  output logic                          done,
  output logic                          err
);

  state_t state_q, state_d;

  logic [MAX_DIM*MAX_DIM*DW-1:0] a_q, b_q;
  logic [MAX_DIM*MAX_DIM*OW-1:0] c_q;
  logic [IDX_W-1:0]              m_q, k_q, n_q;
  logic [IDX_W-1:0]              i_q, j_q, p_q;
  logic                          err_q;

  logic                 bad_dims;
  logic                 p_last, j_last, i_last;
  logic                 mac_step, mac_clear;
  logic signed [DW-1:0] a_el, b_el;
  logic signed [OW-1:0] mac_result;

  assign bad_dims = (m == 8'd0) || (int'(m) > MAX_DIM) ||
                    (k == 8'd0) || (int'(k) > MAX_DIM) ||
                    (n == 8'd0) || (int'(n) > MAX_DIM);

  assign p_last = (p_q == k_q - 8'd1);
  assign j_last = (j_q == n_q - 8'd1);
  assign i_last = (i_q == m_q - 8'd1);

  assign a_el = a_q[elem_off(int'(i_q), int'(p_q), MAX_DIM)*DW +: DW];
  assign b_el = b_q[elem_off(int'(p_q), int'(j_q), MAX_DIM)*DW +: DW];

  assign mac_step  = enable && (state_q == ST_MAC) && !err_q;
  assign mac_clear = enable && (state_q == ST_IDLE) && start;

  matmul_mac #(
    .DW      (DW),
    .MAX_DIM (MAX_DIM),
    .OW      (OW)
  ) u_mac (
    .clk    (clk),
    .reset  (reset),
    .step   (mac_step),
    .clear  (mac_clear),
    .last   (p_last),
    .a      (a_el),
    .b      (b_el),
    .result (mac_result)
  );

  // State register; frozen whenever enable is low.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else if (enable) begin
      state_q <= state_d;
    end
  end

  // Next state: illegal dimensions skip straight from MAC to DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_MAC;
      ST_MAC:  if (err_q || (p_last && j_last && i_last)) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Status outputs decoded from the current state.
  always_comb begin
    busy = (state_q == ST_MAC);
    done = (state_q == ST_DONE);
  end

  // Operand capture, index walk and result write-back.
  always_ff @(posedge clk) begin
    if (!reset) begin
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
      m_q   <= '0;
      k_q   <= '0;
      n_q   <= '0;
      i_q   <= '0;
      j_q   <= '0;
      p_q   <= '0;
      err_q <= 1'b0;
    end else if (enable) begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            a_q   <= A;
            b_q   <= B;
            m_q   <= m;
            k_q   <= k;
            n_q   <= n;
            c_q   <= '0;
            i_q   <= '0;
            j_q   <= '0;
            p_q   <= '0;
            err_q <= bad_dims;
          end
        end
        ST_MAC: begin
          if (!err_q) begin
            if (p_last) begin
              c_q[elem_off(int'(i_q), int'(j_q), MAX_DIM)*OW +: OW] <= mac_result;
              p_q <= '0;
              if (j_last) begin
                j_q <= '0;
                i_q <= i_q + 8'd1;
              end else begin
                j_q <= j_q + 8'd1;
              end
            end else begin
              p_q <= p_q + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign C   = c_q;
  assign err = err_q;

endmodule

// File: tb/tb_matrix_mult_seq.sv
// Directed bench for matrix_mult_seq with default geometry (DW=8, MAX_DIM=4,
// OW=16). Cycle numbers count from 1 starting at the accepting clock edge.
module tb_matrix_mult_seq;

  logic         clk;
  logic         reset;
  logic         enable;
  logic         start;
  logic [7:0]   m, k, n;
  logic [127:0] a_v, b_v;
  logic [255:0] c_v;
  logic         busy, done, err;

  int tests_run;
  int tests_failed;
  int exp_c[16];

  matrix_mult_seq dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .start  (start),
    .m      (m),
    .k      (k),
    .n      (n),
    .A      (a_v),
    .B      (b_v),
    .C      (c_v),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  // Clock generation: 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_a(input int r, input int c, input int v);
    a_v[(r*4+c)*8 +: 8] = 8'(v);
  endtask

  task automatic set_b(input int r, input int c, input int v);
    b_v[(r*4+c)*8 +: 8] = 8'(v);
  endtask

  function automatic int get_c(input int r, input int c);
    logic signed [15:0] t;
    t = c_v[(r*4+c)*16 +: 16];
    return int'(t);
  endfunction

  task automatic clear_exp();
    for (int i = 0; i < 16; i++) exp_c[i] = 0;
  endtask

  task automatic load_basic();
    a_v = '0;
    b_v = '0;
    set_a(0, 0, 1); set_a(0, 1, 2); set_a(1, 0, 3); set_a(1, 1, 4);
    set_b(0, 0, 5); set_b(0, 1, 6); set_b(1, 0, 7); set_b(1, 1, 8);
    clear_exp();
    exp_c[0] = 19; exp_c[1] = 22; exp_c[4] = 43; exp_c[5] = 50;
  endtask

  // Launch one job and wait (bounded) for done; cyc = -1 on timeout.
  task automatic run_op(input int mm, input int kk, input int nn, output int cyc);
    @(negedge clk);
    m = 8'(mm);
    k = 8'(kk);
    n = 8'(nn);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = -1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (done) begin
        cyc = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset  = 1'b0;
    enable = 1'b1;
    start  = 1'b0;
    m = 8'd0; k = 8'd0; n = 8'd0;
    a_v = '0; b_v = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b expected 0", busy); end
    tests_run++;
    if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b expected 0", done); end
    tests_run++;
    if (err !== 1'b0) begin tests_failed++; $display("FAIL reset_err got %b expected 0", err); end
    tests_run++;
    if (c_v !== 256'd0) begin tests_failed++; $display("FAIL reset_c got %h expected 0", c_v); end
    reset = 1'b1;
  endtask

  task automatic test_basic();
    int cyc;
    load_basic();
    run_op(2, 2, 2, cyc);
    tests_run++;
    if (cyc !== 9) begin tests_failed++; $display("FAIL basic_latency got %0d expected 9", cyc); end
    tests_run++;
    if (err !== 1'b0) begin tests_failed++; $display("FAIL basic_err got %b expected 0", err); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL basic_busy_at_done got %b expected 0", busy); end
    for (int i = 0; i < 16; i++) begin
      tests_run++;
      if (get_c(i/4, i%4) !== exp_c[i]) begin
        tests_failed++;
        $display("FAIL basic_c[%0d][%0d] got %0d expected %0d", i/4, i%4, get_c(i/4, i%4), exp_c[i]);
      end
    end
    @(negedge clk);
    tests_run++;
    if (done !== 1'b0) begin tests_failed++; $display("FAIL basic_done_pulse got %b expected 0", done); end
  endtask

  task automatic test_rect();
    int cyc;
    a_v = '0;
    b_v = '0;
    set_a(0, 0, 1);  set_a(0, 1, -2); set_a(0, 2, 3);
    set_a(1, 0, -4); set_a(1, 1, 5);  set_a(1, 2, -6);
    set_b(0, 0, 7);  set_b(1, 0, 8);  set_b(2, 0, 9);
    clear_exp();
    exp_c[0] = 18;
    exp_c[4] = -42;
    run_op(2, 3, 1, cyc);
    tests_run++;
    if (cyc !== 7) begin tests_failed++; $display("FAIL rect_latency got %0d expected 7", cyc); end
    for (int i = 0; i < 16; i++) begin
      tests_run++;
      if (get_c(i/4, i%4) !== exp_c[i]) begin
        tests_failed++;
        $display("FAIL rect_c[%0d][%0d] got %0d expected %0d", i/4, i%4, get_c(i/4, i%4), exp_c[i]);
      end
    end
  endtask

  // All-127 4x4x4: each dot product is 4*127*127 = 64516, beyond the OW=16 range.
  task automatic test_overflow();
    int cyc;
    int expv;
`ifdef MATMUL_SATURATE_EN
    expv = 32767;
`else
    expv = -1020;
`endif
    for (int i = 0; i < 16; i++) begin
      a_v[i*8 +: 8] = 8'd127;
      b_v[i*8 +: 8] = 8'd127;
    end
    run_op(4, 4, 4, cyc);
    tests_run++;
    if (cyc !== 65) begin tests_failed++; $display("FAIL overflow_latency got %0d expected 65", cyc); end
    for (int i = 0; i < 16; i++) begin
      tests_run++;
      if (get_c(i/4, i%4) !== expv) begin
        tests_failed++;
        $display("FAIL overflow_c[%0d][%0d] got %0d expected %0d", i/4, i%4, get_c(i/4, i%4), expv);
      end
    end
  endtask

  task automatic test_err_dims();
    int cyc;
    load_basic();
    run_op(0, 2, 2, cyc);
    tests_run++;
    if (cyc !== 2) begin tests_failed++; $display("FAIL err_latency got %0d expected 2", cyc); end
    tests_run++;
    if (err !== 1'b1) begin tests_failed++; $display("FAIL err_flag got %b expected 1", err); end
    tests_run++;
    if (c_v !== 256'd0) begin tests_failed++; $display("FAIL err_c got %h expected 0", c_v); end
    // Stalling with done pending must stretch the pulse.
    enable = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (done !== 1'b1) begin tests_failed++; $display("FAIL err_done_held got %b expected 1", done); end
    enable = 1'b1;
    @(negedge clk);
    tests_run++;
    if (done !== 1'b0) begin tests_failed++; $display("FAIL err_done_release got %b expected 0", done); end
    run_op(5, 1, 1, cyc);
    tests_run++;
    if (cyc !== 2 || err !== 1'b1) begin
      tests_failed++;
      $display("FAIL err_oversize got cyc=%0d err=%b expected cyc=2 err=1", cyc, err);
    end
    a_v = '0;
    b_v = '0;
    set_a(0, 0, 3);
    set_b(0, 0, -5);
    run_op(1, 1, 1, cyc);
    tests_run++;
    if (cyc !== 2) begin tests_failed++; $display("FAIL unit_latency got %0d expected 2", cyc); end
    tests_run++;
    if (err !== 1'b0) begin tests_failed++; $display("FAIL unit_err got %b expected 0", err); end
    tests_run++;
    if (get_c(0, 0) !== -15) begin tests_failed++; $display("FAIL unit_c00 got %0d expected -15", get_c(0, 0)); end
  endtask

  // Stray start mid-run, operand changes after acceptance, 5-cycle enable stall.
  task automatic test_stall_ignore();
    int cyc;
    load_basic();
    @(negedge clk);
    m = 8'd2; k = 8'd2; n = 8'd2;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = -1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (c == 3) begin
        start = 1'b1;
        m = 8'd3;
        a_v = {4{32'h7f7f7f7f}};
        b_v = {4{32'h81818181}};
      end
      if (c == 4) begin
        start = 1'b0;
        enable = 1'b0;
      end
      if (c == 6) begin
        tests_run++;
        if (busy !== 1'b1) begin tests_failed++; $display("FAIL stall_busy got %b expected 1", busy); end
      end
      if (c == 9) enable = 1'b1;
      if (done) begin
        cyc = c;
        break;
      end
    end
    tests_run++;
    if (cyc !== 14) begin tests_failed++; $display("FAIL stall_latency got %0d expected 14", cyc); end
    for (int i = 0; i < 16; i++) begin
      tests_run++;
      if (get_c(i/4, i%4) !== exp_c[i]) begin
        tests_failed++;
        $display("FAIL stall_c[%0d][%0d] got %0d expected %0d", i/4, i%4, get_c(i/4, i%4), exp_c[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    load_basic();
    @(negedge clk);
    m = 8'd2; k = 8'd2; n = 8'd2;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (busy !== 1'b1 || get_c(0, 0) !== 19) begin
      tests_failed++;
      $display("FAIL midrun_state got busy=%b c00=%0d expected busy=1 c00=19", busy, get_c(0, 0));
    end
    reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_flags got busy=%b done=%b err=%b expected 0 0 0", busy, done, err);
    end
    tests_run++;
    if (c_v !== 256'd0) begin tests_failed++; $display("FAIL midreset_c got %h expected 0", c_v); end
    reset = 1'b1;
    run_op(2, 2, 2, cyc);
    tests_run++;
    if (cyc !== 9) begin tests_failed++; $display("FAIL postreset_latency got %0d expected 9", cyc); end
    for (int i = 0; i < 16; i++) begin
      tests_run++;
      if (get_c(i/4, i%4) !== exp_c[i]) begin
        tests_failed++;
        $display("FAIL postreset_c[%0d][%0d] got %0d expected %0d", i/4, i%4, get_c(i/4, i%4), exp_c[i]);
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_basic();
    test_rect();
    test_overflow();
    test_err_dims();
    test_stall_ignore();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
